dmem_arbiter: RTL

//  Shares the single-port byte-addressed data memory between two requesters (port 0 = core LSU, port 1 = debug/DMA).

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port byte-addressed data memory between two requesters.
// One transaction in flight; sub-word stores are done as read-modify-write, loads are RV32I-extended.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_funct3,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_funct3,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RMW_RD = 2'd2;
  localparam logic [1:0] S_RMW_WR = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] old_q, old_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;

  logic          idle;
  logic          gnt_we;
  logic [2:0]    gnt_f3;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;

  assign idle = (state_q == S_IDLE);

  // rr_q=0 favours port 0 when both request
  assign m0_gnt = idle & ~rst & m0_req & (~m1_req | ~rr_q);
  assign m1_gnt = idle & ~rst & m1_req & (~m0_req |  rr_q);

  assign gnt_we = m1_gnt ? m1_we     : m0_we;
  assign gnt_f3 = m1_gnt ? m1_funct3 : m0_funct3;

  always_comb begin
    load_ext = mem_rdata;
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & mem_rdata[7]}},  mem_rdata[7:0]};
      2'b01:   load_ext = {{16{~f3_q[2] & mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  assign merged = f3_q[0] ? {old_q[31:16], wdata_q[15:0]} : {old_q[31:8], wdata_q[7:0]};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    port_d  = port_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_gnt | m1_gnt) begin
          port_d  = m1_gnt;
          rr_d    = m0_gnt;
          we_d    = gnt_we;
          f3_d    = gnt_f3;
          addr_d  = m1_gnt ? m1_addr  : m0_addr;
          wdata_d = m1_gnt ? m1_wdata : m0_wdata;
          // funct3[1]=0 means byte/half; stores of those need the old word first
          state_d = (gnt_we & ~gnt_f3[1]) ? S_RMW_RD : S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = we_q ? '0 : load_ext;
        rv0_d   = ~port_q;
        rv1_d   = port_q;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        old_d   = mem_rdata;
        state_d = S_RMW_WR;
      end
      default: begin
        rdata_d = '0;
        rv0_d   = ~port_q;
        rv1_d   = port_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? rdata_q : '0;
  assign m1_rdata  = rv1_q ? rdata_q : '0;

  assign mem_ce   = ~rst & ~idle;
  assign mem_we   = ~rst & (((state_q == S_ACCESS) & we_q) | (state_q == S_RMW_WR));
  assign mem_addr = idle ? '0 : addr_q;
  assign busy     = ~idle;

  always_comb begin
    mem_wdata = '0;
    if (state_q == S_ACCESS && we_q) mem_wdata = wdata_q;
    else if (state_q == S_RMW_WR)    mem_wdata = merged;
  end

endmodule
